// File: rtl/ifid_fetch_stage.sv
// rtl/ifid_fetch_stage.sv - PC owner, single-outstanding imem fetch and IF/ID register
// Optional IFID_PERF_CNT_EN adds perf_fetch/perf_starve/perf_kill counters.
module ifid_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pcwrite,
    input  logic [31:0] branch_target,
    input  logic        ifid_bubble,
    input  logic        ifid_flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_inst,
    output logic        ifid_valid,
    output logic        fetch_busy
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_starve,
    output logic [31:0] perf_kill
`endif
);

    typedef enum logic [1:0] {S_BOOT, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t      state, next_state;
    logic [31:0] pc;
    logic        kill;
    logic        hold_vld;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;

    logic        resp_in, resp_avail, redirect, load, park, kill_drop, starve;
    logic [31:0] resp_inst, resp_pc;

    always_comb begin
        resp_in    = (state == S_WAIT) && imem_valid && !kill;
        resp_avail = hold_vld || resp_in;
        redirect   = (pcwrite == 2'b10);
        load       = !ifid_flush && !ifid_bubble && resp_avail && (pcwrite == 2'b00);
        // A response survives only if nothing consumes or discards it this edge
        park       = resp_avail && !load && !ifid_flush && !redirect;
        kill_drop  = (state == S_WAIT) && imem_valid && kill;
        starve     = !ifid_flush && !ifid_bubble && !load;
        resp_inst  = hold_vld ? hold_inst : imem_rdata;
        resp_pc    = hold_vld ? hold_pc : pc;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_BOOT:  next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  if (imem_valid) next_state = park ? S_HOLD : S_ISSUE;
            S_HOLD:  next_state = park ? S_HOLD : S_ISSUE;
            default: next_state = S_BOOT;
        endcase
    end

    assign imem_req   = (state == S_ISSUE);
    assign imem_addr  = pc;
    assign fetch_busy = (state == S_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_BOOT;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            hold_vld   <= 1'b0;
            hold_inst  <= NOP_INST;
            hold_pc    <= 32'h0;
            ifid_pc    <= 32'h0;
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end else begin
            state    <= next_state;
            hold_vld <= park;
            if (park) begin
                hold_inst <= resp_inst;
                hold_pc   <= resp_pc;
            end

            if (kill_drop || ((state == S_WAIT) && imem_valid))
                kill <= 1'b0;
            else if (redirect && ((state == S_ISSUE) || (state == S_WAIT)))
                kill <= 1'b1;

            if (redirect)
                pc <= branch_target & 32'hFFFF_FFFC;
            else if (load)
                pc <= pc + 32'd4;

            if (ifid_flush) begin
                ifid_inst  <= NOP_INST;
                ifid_valid <= 1'b0;
            end else if (!ifid_bubble) begin
                if (load) begin
                    ifid_inst  <= resp_inst;
                    ifid_pc    <= resp_pc;
                    ifid_valid <= 1'b1;
                end else begin
                    ifid_inst  <= NOP_INST;
                    ifid_valid <= 1'b0;
                end
            end
        end
    end

`ifdef IFID_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch  <= 32'h0;
            perf_starve <= 32'h0;
            perf_kill   <= 32'h0;
        end else begin
            if (load)      perf_fetch  <= perf_fetch + 32'd1;
            if (starve)    perf_starve <= perf_starve + 32'd1;
            if (kill_drop) perf_kill   <= perf_kill + 32'd1;
        end
    end
`endif

endmodule
